// File: rtl/fll_cfg_ctrl_if.sv
// Bus bundles for fll_cfg_ctrl: the SoC-side software access port and the
// four-phase FLL configuration port. Signal names keep the controller's view.
interface fll_cfg_ctrl_if;
   logic        cfg_req_i;
   logic        cfg_wrn_i;
   logic [1:0]  cfg_add_i;
   logic [31:0] cfg_wdata_i;
   logic        cfg_gnt_o;
   logic        cfg_rvalid_o;
   logic [31:0] cfg_rdata_o;

   modport master (
      output cfg_req_i, cfg_wrn_i, cfg_add_i, cfg_wdata_i,
      input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
   );

   modport slave (
      input  cfg_req_i, cfg_wrn_i, cfg_add_i, cfg_wdata_i,
      output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
   );
endinterface

interface fll_port_if;
   logic        fll_req_o;
   logic        fll_wrn_o;
   logic [1:0]  fll_add_o;
   logic [31:0] fll_data_o;
   logic        fll_ack_i;
   logic [31:0] fll_r_data_i;

   modport master (
      output fll_req_o, fll_wrn_o, fll_add_o, fll_data_o,
      input  fll_ack_i, fll_r_data_i
   );

   modport slave (
      input  fll_req_o, fll_wrn_o, fll_add_o, fll_data_o,
      output fll_ack_i, fll_r_data_i
   );
endinterface

// File: rtl/fll_cfg_ctrl.sv
// FLL configuration sequencer: boot-programs two FLL registers, waits for a
// stable lock, selects the FLL clock and then serves software FLL accesses.
module fll_cfg_ctrl #(
   parameter logic [31:0] BOOT_CFG1    = 32'h0000_0000,
   parameter logic [31:0] BOOT_CFG2    = 32'h0000_0000,
   parameter int unsigned LOCK_TIMEOUT = 1024,
   parameter int unsigned LOCK_STABLE  = 8
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   fll_cfg_ctrl_if.slave cfg,
   fll_port_if.master    fll,
   input  logic          fll_lock_i,
   output logic          clk_sel_o,
   output logic          boot_done_o,
   output logic          lock_err_o
);

   localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [SW-1:0] STB_LAST = SW'(LOCK_STABLE - 1);

   typedef enum logic [2:0] {
      B1_REQ = 3'd0,
      B1_REL = 3'd1,
      B2_REQ = 3'd2,
      B2_REL = 3'd3,
      LOCK   = 3'd4,
      READY  = 3'd5,
      S_REQ  = 3'd6,
      S_REL  = 3'd7
   } state_t;

   state_t        state_q;
   logic          req_q;
   logic          wrn_q;
   logic [1:0]    add_q;
   logic [31:0]   data_q;
   logic [TW-1:0] tmr_q;
   logic [SW-1:0] stb_q;
   logic [31:0]   rbuf_q;
   logic          rvalid_q;
   logic [31:0]   rdata_q;
   logic          clk_sel_q;
   logic          boot_done_q;
   logic          lock_err_q;
   logic          gnt_s;
   logic          relock_s;

   assign gnt_s    = (state_q == READY) & cfg.cfg_req_i;
   // A completed software write to address 1 reprograms the FLL and forces a new lock phase.
   assign relock_s = (~wrn_q) & (add_q == 2'd1);

   // Sequencer FSM with all outputs except the grant registered.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= B1_REQ;
         req_q       <= 1'b0;
         wrn_q       <= 1'b0;
         add_q       <= 2'd0;
         data_q      <= 32'h0000_0000;
         tmr_q       <= {TW{1'b0}};
         stb_q       <= {SW{1'b0}};
         rbuf_q      <= 32'h0000_0000;
         rvalid_q    <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         clk_sel_q   <= 1'b0;
         boot_done_q <= 1'b0;
         lock_err_q  <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         rdata_q  <= 32'h0000_0000;
         case (state_q)
            // req_q is low only on the first cycle after reset; it is raised here.
            B1_REQ: begin
               if (req_q && fll.fll_ack_i) begin
                  req_q   <= 1'b0;
                  state_q <= B1_REL;
               end else begin
                  req_q  <= 1'b1;
                  wrn_q  <= 1'b0;
                  add_q  <= 2'd1;
                  data_q <= BOOT_CFG1;
               end
            end
            B1_REL: begin
               if (!fll.fll_ack_i) begin
                  req_q   <= 1'b1;
                  wrn_q   <= 1'b0;
                  add_q   <= 2'd2;
                  data_q  <= BOOT_CFG2;
                  state_q <= B2_REQ;
               end
            end
            B2_REQ: begin
               if (fll.fll_ack_i) begin
                  req_q   <= 1'b0;
                  state_q <= B2_REL;
               end
            end
            B2_REL: begin
               if (!fll.fll_ack_i) begin
                  tmr_q   <= {TW{1'b0}};
                  stb_q   <= {SW{1'b0}};
                  state_q <= LOCK;
               end
            end
            // Stable lock wins over a timeout that expires on the same cycle.
            LOCK: begin
               if (fll_lock_i && (stb_q == STB_LAST)) begin
                  clk_sel_q   <= 1'b1;
                  boot_done_q <= 1'b1;
                  state_q     <= READY;
               end else if (tmr_q == TMO_LAST) begin
                  clk_sel_q   <= 1'b0;
                  lock_err_q  <= 1'b1;
                  boot_done_q <= 1'b1;
                  state_q     <= READY;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
                  stb_q <= fll_lock_i ? (stb_q + SW'(1)) : {SW{1'b0}};
               end
            end
            READY: begin
               if (clk_sel_q && !fll_lock_i) begin
                  clk_sel_q  <= 1'b0;
                  lock_err_q <= 1'b1;
               end
               if (gnt_s) begin
                  req_q   <= 1'b1;
                  wrn_q   <= cfg.cfg_wrn_i;
                  add_q   <= cfg.cfg_add_i;
                  data_q  <= cfg.cfg_wdata_i;
                  state_q <= S_REQ;
                  if (!cfg.cfg_wrn_i && (cfg.cfg_add_i == 2'd1)) begin
                     clk_sel_q <= 1'b0;
                  end
               end
            end
            S_REQ: begin
               if (fll.fll_ack_i) begin
                  req_q   <= 1'b0;
                  rbuf_q  <= fll.fll_r_data_i;
                  state_q <= S_REL;
               end
            end
            S_REL: begin
               if (!fll.fll_ack_i) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= wrn_q ? rbuf_q : 32'h0000_0000;
                  if (relock_s) begin
                     lock_err_q <= 1'b0;
                     tmr_q      <= {TW{1'b0}};
                     stb_q      <= {SW{1'b0}};
                     state_q    <= LOCK;
                  end else begin
                     state_q <= READY;
                  end
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= B1_REQ;
            end
         endcase
      end
   end

   assign cfg.cfg_gnt_o    = gnt_s;
   assign cfg.cfg_rvalid_o = rvalid_q;
   assign cfg.cfg_rdata_o  = rdata_q;
   assign fll.fll_req_o    = req_q;
   assign fll.fll_wrn_o    = wrn_q;
   assign fll.fll_add_o    = add_q;
   assign fll.fll_data_o   = data_q;
   assign clk_sel_o        = clk_sel_q;
   assign boot_done_o      = boot_done_q;
   assign lock_err_o       = lock_err_q;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Scoreboard bench for fll_cfg_ctrl: directed stimulus queues the expected FLL
// transactions and software responses, a monitor pops them as the DUT emits them.
module tb_fll_cfg_ctrl;
   localparam logic [31:0] CFG1 = 32'h1234_5678;
   localparam logic [31:0] CFG2 = 32'h9ABC_DEF0;
   localparam int unsigned TMO  = 64;
   localparam int unsigned STB  = 8;

   typedef struct packed {
      logic        wrn;
      logic [1:0]  add;
      logic [31:0] data;
   } txn_t;

   logic clk = 1'b0;
   logic rstn;
   logic lock;
   logic ack_tie;
   logic ack_dly = 1'b0;
   int   ack_delay = 5;
   int   ack_cnt = 0;
   logic clk_sel, boot_done, lock_err;

   txn_t        fll_q[$];
   logic [31:0] rsp_q[$];
   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int a, b;

   fll_cfg_ctrl_if cfg_bus ();
   fll_port_if     fll_bus ();

   fll_cfg_ctrl #(
      .BOOT_CFG1   (CFG1),
      .BOOT_CFG2   (CFG2),
      .LOCK_TIMEOUT(TMO),
      .LOCK_STABLE (STB)
   ) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .cfg        (cfg_bus),
      .fll        (fll_bus),
      .fll_lock_i (lock),
      .clk_sel_o  (clk_sel),
      .boot_done_o(boot_done),
      .lock_err_o (lock_err)
   );

   always #5 clk = ~clk;

   assign fll_bus.fll_ack_i = ack_tie ? fll_bus.fll_req_o : ack_dly;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) tick();
   endtask

   // Issue one software request, return the cycle in which it was granted.
   task automatic xfer(input logic wrn, input logic [1:0] add, input logic [31:0] wd,
                       output int gcyc);
      bit got;
      got = 1'b0;
      cfg_bus.cfg_req_i   = 1'b1;
      cfg_bus.cfg_wrn_i   = wrn;
      cfg_bus.cfg_add_i   = add;
      cfg_bus.cfg_wdata_i = wd;
      for (int i = 0; i < 64 && !got; i++) begin
         #1;
         if (cfg_bus.cfg_gnt_o) got = 1'b1;
         else tick();
      end
      gcyc = cyc;
      chk("grant_wait", {31'd0, got}, 32'd1);
      tick();
      cfg_bus.cfg_req_i = 1'b0;
   endtask

   // FLL model for delayed-ack mode: ack rises after ack_delay cycles of req.
   initial begin
      forever begin
         @(negedge clk);
         if (fll_bus.fll_req_o) begin
            ack_cnt++;
            ack_dly = (ack_cnt >= ack_delay);
         end else begin
            ack_cnt = 0;
            ack_dly = 1'b0;
         end
      end
   end

   // Monitor: FLL request rising edges and cfg completions are checked against the queues.
   initial begin
      logic prev;
      txn_t e;
      logic [31:0] r;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (fll_bus.fll_req_o && !prev) begin
            if (fll_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL fll_unexpected at cycle %0d: got add=%0d data=%h expected no request",
                        cyc, fll_bus.fll_add_o, fll_bus.fll_data_o);
            end else begin
               e = fll_q.pop_front();
               chk("fll_wrn", {31'd0, fll_bus.fll_wrn_o}, {31'd0, e.wrn});
               chk("fll_add", {30'd0, fll_bus.fll_add_o}, {30'd0, e.add});
               chk("fll_data", fll_bus.fll_data_o, e.data);
            end
         end
         prev = fll_bus.fll_req_o;
         if (cfg_bus.cfg_rvalid_o) begin
            if (rsp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL rvalid_unexpected at cycle %0d: got rdata=%h expected no pulse",
                        cyc, cfg_bus.cfg_rdata_o);
            end else begin
               r = rsp_q.pop_front();
               chk("cfg_rdata", cfg_bus.cfg_rdata_o, r);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      lock = 1'b1;
      ack_tie = 1'b1;
      cfg_bus.cfg_req_i   = 1'b0;
      cfg_bus.cfg_wrn_i   = 1'b0;
      cfg_bus.cfg_add_i   = 2'd0;
      cfg_bus.cfg_wdata_i = 32'h0000_0000;
      fll_bus.fll_r_data_i = 32'h0BAD_CAFE;
      repeat (3) @(negedge clk);

      // Reset values; a pending request must not be granted during reset.
      cfg_bus.cfg_req_i   = 1'b1;
      cfg_bus.cfg_wrn_i   = 1'b1;
      cfg_bus.cfg_add_i   = 2'd0;
      cfg_bus.cfg_wdata_i = 32'h5555_0000;
      #1;
      chk("rst_gnt", {31'd0, cfg_bus.cfg_gnt_o}, 32'd0);
      chk("rst_req", {31'd0, fll_bus.fll_req_o}, 32'd0);
      chk("rst_add", {30'd0, fll_bus.fll_add_o}, 32'd0);
      chk("rst_data", fll_bus.fll_data_o, 32'd0);
      chk("rst_rvalid", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd0);
      chk("rst_clk_sel", {31'd0, clk_sel}, 32'd0);
      chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
      chk("rst_lock_err", {31'd0, lock_err}, 32'd0);

      // Boot with lock held; the request issued during boot is served once READY.
      fll_q.push_back('{1'b0, 2'd1, CFG1});
      fll_q.push_back('{1'b0, 2'd2, CFG2});
      fll_q.push_back('{1'b1, 2'd0, 32'h5555_0000});
      rsp_q.push_back(32'h0BAD_CAFE);
      @(negedge clk);
      rstn = 1'b1;
      cyc = -1;
      goto_cyc(5);
      chk("boot_gnt_c5", {31'd0, cfg_bus.cfg_gnt_o}, 32'd0);
      goto_cyc(11);
      chk("boot_gnt_c11", {31'd0, cfg_bus.cfg_gnt_o}, 32'd0);
      chk("boot_clk_sel_c11", {31'd0, clk_sel}, 32'd0);
      chk("boot_done_c11", {31'd0, boot_done}, 32'd0);
      goto_cyc(12);
      chk("boot_clk_sel_c12", {31'd0, clk_sel}, 32'd1);
      chk("boot_done_c12", {31'd0, boot_done}, 32'd1);
      chk("boot_lock_err", {31'd0, lock_err}, 32'd0);
      chk("boot_gnt_c12", {31'd0, cfg_bus.cfg_gnt_o}, 32'd1);
      tick();
      cfg_bus.cfg_req_i = 1'b0;
      goto_cyc(14);
      chk("rd0_rvalid_a2", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd0);
      goto_cyc(15);
      chk("rd0_rvalid_a3", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd1);
      goto_cyc(16);
      chk("rd0_rvalid_a4", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd0);

      // Read address 3 with the FLL acknowledging 5 cycles late.
      fll_bus.fll_r_data_i = 32'hCAFE_F00D;
      ack_tie = 1'b0;
      fll_q.push_back('{1'b1, 2'd3, 32'h0000_0000});
      rsp_q.push_back(32'hCAFE_F00D);
      xfer(1'b1, 2'd3, 32'h0000_0000, a);
      goto_cyc(a + 5);
      chk("rd3_req_held", {31'd0, fll_bus.fll_req_o}, 32'd1);
      goto_cyc(a + 6);
      chk("rd3_rvalid_a6", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd0);
      goto_cyc(a + 7);
      chk("rd3_rvalid_a7", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd1);
      goto_cyc(a + 8);
      chk("rd3_rvalid_a8", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd0);
      ack_tie = 1'b1;

      // Write address 1: clock deselect, relock, reselect.
      fll_q.push_back('{1'b0, 2'd1, 32'h0000_00A5});
      rsp_q.push_back(32'h0000_0000);
      xfer(1'b0, 2'd1, 32'h0000_00A5, a);
      chk("wr1_clk_sel_a1", {31'd0, clk_sel}, 32'd0);
      goto_cyc(a + 3);
      chk("wr1_rvalid_a3", {31'd0, cfg_bus.cfg_rvalid_o}, 32'd1);
      chk("wr1_boot_done", {31'd0, boot_done}, 32'd1);
      goto_cyc(a + 10);
      chk("wr1_clk_sel_a10", {31'd0, clk_sel}, 32'd0);
      goto_cyc(a + 11);
      chk("wr1_clk_sel_a11", {31'd0, clk_sel}, 32'd1);

      // One-cycle lock loss in READY.
      tick();
      lock = 1'b0;
      b = cyc;
      tick();
      lock = 1'b1;
      chk("loss_clk_sel_b1", {31'd0, clk_sel}, 32'd0);
      chk("loss_err_b1", {31'd0, lock_err}, 32'd1);
      goto_cyc(b + 4);
      chk("loss_clk_sel_b4", {31'd0, clk_sel}, 32'd0);
      chk("loss_err_b4", {31'd0, lock_err}, 32'd1);

      // Write address 2 must not touch the clock selection or error.
      fll_q.push_back('{1'b0, 2'd2, 32'h0000_0077});
      rsp_q.push_back(32'h0000_0000);
      xfer(1'b0, 2'd2, 32'h0000_0077, a);
      goto_cyc(a + 3);
      chk("wr2_err_kept", {31'd0, lock_err}, 32'd1);
      chk("wr2_clk_sel_kept", {31'd0, clk_sel}, 32'd0);

      // Rewriting address 1 clears the error at completion and relocks.
      fll_q.push_back('{1'b0, 2'd1, 32'h0000_005A});
      rsp_q.push_back(32'h0000_0000);
      xfer(1'b0, 2'd1, 32'h0000_005A, a);
      goto_cyc(a + 2);
      chk("rec_err_a2", {31'd0, lock_err}, 32'd1);
      goto_cyc(a + 3);
      chk("rec_err_a3", {31'd0, lock_err}, 32'd0);
      goto_cyc(a + 11);
      chk("rec_clk_sel_a11", {31'd0, clk_sel}, 32'd1);

      // Reset from READY, then again in the middle of B2_REQ.
      fll_q.push_back('{1'b0, 2'd1, CFG1});
      fll_q.push_back('{1'b0, 2'd2, CFG2});
      fll_q.push_back('{1'b0, 2'd1, CFG1});
      fll_q.push_back('{1'b0, 2'd2, CFG2});
      tick();
      rstn = 1'b0;
      #1;
      chk("rst2_clk_sel", {31'd0, clk_sel}, 32'd0);
      chk("rst2_boot_done", {31'd0, boot_done}, 32'd0);
      tick();
      rstn = 1'b1;
      cyc = -1;
      goto_cyc(2);
      chk("b2req_req", {31'd0, fll_bus.fll_req_o}, 32'd1);
      chk("b2req_add", {30'd0, fll_bus.fll_add_o}, 32'd2);
      #2;
      rstn = 1'b0;
      #1;
      chk("rst3_req", {31'd0, fll_bus.fll_req_o}, 32'd0);
      chk("rst3_add", {30'd0, fll_bus.fll_add_o}, 32'd0);
      chk("rst3_data", fll_bus.fll_data_o, 32'd0);
      lock = 1'b0;
      tick();
      rstn = 1'b1;
      cyc = -1;

      // Boot with no lock: timeout error.
      goto_cyc(67);
      chk("tmo_err_c67", {31'd0, lock_err}, 32'd0);
      chk("tmo_done_c67", {31'd0, boot_done}, 32'd0);
      goto_cyc(68);
      chk("tmo_err_c68", {31'd0, lock_err}, 32'd1);
      chk("tmo_done_c68", {31'd0, boot_done}, 32'd1);
      chk("tmo_clk_sel_c68", {31'd0, clk_sel}, 32'd0);
      tick();
      tick();
      chk("fll_q_empty", fll_q.size(), 32'd0);
      chk("rsp_q_empty", rsp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/fll_cfg_ctrl.md
# fll_cfg_ctrl

FLL configuration sequencer that sits between the SoC register bus and the FLL configuration port of the clock/reset generator. After reset it programs two FLL configuration registers from parameters. It then waits for a stable lock before selecting the FLL clock. Afterwards it gives software access to the FLL registers, and it falls back to the reference clock on lock loss or lock timeout.

## Interface
- `BOOT_CFG1`, default 32'h0000_0000: value written to FLL address 1 during boot.
- `BOOT_CFG2`, default 32'h0000_0000: value written to FLL address 2 during boot.
- `LOCK_TIMEOUT`, default 1024: maximum cycles spent in LOCK before the block declares an error (≥2).
- `LOCK_STABLE`, default 8: number of consecutive cycles `fll_lock_i`=1 required to declare lock (≥1, < LOCK_TIMEOUT).

Ports:
- `clk_i`  in  1  reference clock; the only clock of the block.
- `rstn_i`  in  1  asynchronous reset, active low.
- `cfg_req_i`  in  1  software request; held until `cfg_gnt_o`.
- `cfg_wrn_i`  in  1  0 = write, 1 = read.
- `cfg_add_i`  in  2  FLL register address.
- `cfg_wdata_i`  in  32  write data.
- `cfg_gnt_o`  out  1  request accepted (combinational).
- `cfg_rvalid_o`  out  1  one-cycle completion pulse, for both reads and writes.
- `cfg_rdata_o`  out  32  read data; valid while `cfg_rvalid_o`=1.
- `fll_req_o`, `fll_wrn_o`  out  1  FLL handshake request and write-not.
- `fll_add_o`  out  2  FLL address.
- `fll_data_o`  out  32  FLL write data.
- `fll_ack_i`  in  1  FLL acknowledge; may be combinationally equal to `fll_req_o`.
- `fll_r_data_i`  in  32  FLL read data.
- `fll_lock_i`  in  1  FLL lock indication.
- `clk_sel_o`  out  1  1 = select the FLL clock.
- `boot_done_o`  out  1  sticky; set on the first entry to READY.
- `lock_err_o`  out  1  sticky lock-timeout or lock-loss flag.

## Operation
- States: B1_REQ → B1_REL → B2_REQ → B2_REL → LOCK → READY; S_REQ → S_REL (software transaction).
- All outputs are registered except `cfg_gnt_o`. Reset value of every output is 0.
- Four-phase handshake:
  - *_REQ: `fll_req_o`=1, with address, data and wrn stable. Advance when `fll_ack_i`=1 is sampled; a read captures `fll_r_data_i` on that sample.
  - *_REL: `fll_req_o`=0. Advance when `fll_ack_i`=0 is sampled.
  - There is no acknowledge timeout; a missing ack stalls the block indefinitely.
- Boot sequence: write `BOOT_CFG1` to address 1, then `BOOT_CFG2` to address 2 (wrn=0 for both), then enter LOCK.
- LOCK state:
  - The timer and the stable counter both start at 0 on entry.
  - The stable counter increments while `fll_lock_i`=1 and clears to 0 when `fll_lock_i`=0.
  - On reaching LOCK_STABLE: go to READY and set `clk_sel_o`=1.
  - Else, when the timer reaches LOCK_TIMEOUT-1: go to READY with `clk_sel_o`=0 and `lock_err_o`=1.
- READY state:
  - `cfg_gnt_o` = `cfg_req_i`, only in READY.
  - On grant: latch wrn/add/wdata and go to S_REQ.
  - After S_REL completes, pulse `cfg_rvalid_o`. For reads, `cfg_rdata_o` = captured data; for writes it is 0.
- Software write to address 1: `clk_sel_o`→0 on the cycle after grant. `lock_err_o` is cleared when the handshake completes. After completion, go to LOCK instead of READY; `cfg_rvalid_o` still pulses.
- Lock loss: in READY, `fll_lock_i`=0 while `clk_sel_o`=1 sets `clk_sel_o`=0 and `lock_err_o`=1 on the next cycle. The block stays in READY and does not re-lock until software writes address 1.
- Requests outside READY (during boot, LOCK, or a transaction) are stalled with `cfg_gnt_o`=0.
- Async reset at any point aborts the transaction, drops `fll_req_o` and restarts at B1_REQ.

## Timing
- With combinational ack, the boot writes occupy cycles 0–3 after reset release, and LOCK starts at cycle 4.
- If `fll_lock_i` is held at 1, `clk_sel_o` and `boot_done_o` rise at cycle 4+LOCK_STABLE.
- Software transaction with combinational ack, grant at cycle A:
  - A+1: S_REQ.
  - A+2: S_REL.
  - A+3: `cfg_rvalid_o`=1, and the block is in READY again (a new grant is possible in the same cycle).
- Lock loss reaction: 1 cycle.
- Lock-loss error with `fll_lock_i`=0 throughout: `lock_err_o`=1 at cycle 4+LOCK_TIMEOUT.

## Test plan
- Reset release, ack tied to req, `fll_lock_i`=1, LOCK_STABLE=8 → exactly two FLL writes: (add 1, BOOT_CFG1), then (add 2, BOOT_CFG2). `clk_sel_o` and `boot_done_o` rise at cycle 12; `lock_err_o`=0.
- `fll_lock_i`=0 throughout, LOCK_TIMEOUT=64 → `lock_err_o`=1 and `boot_done_o`=1 at cycle 68; `clk_sel_o`=0.
- In READY, read address 3 with `fll_r_data_i`=32'hCAFE_F00D and ack delayed 5 cycles → `fll_req_o` held until ack; one `cfg_rvalid_o` pulse with `cfg_rdata_o`=32'hCAFE_F00D.
- In READY with `clk_sel_o`=1, write address 1 → `clk_sel_o` drops at A+1, the block re-enters LOCK, and after LOCK_STABLE cycles of lock `clk_sel_o` returns to 1.
- Drop `fll_lock_i` for 1 cycle while in READY → `clk_sel_o`=0 and `lock_err_o`=1 next cycle, and both hold after lock returns. A request issued during boot is not granted until READY.
- Assert `rstn_i` low while in B2_REQ → all outputs 0 immediately; after release, boot restarts from the address-1 write.
